// File: rtl/counter_arbiter_if.sv
// rtl/counter_arbiter_if.sv - request/grant bundle between two requesters and the shared counter
interface counter_arbiter_if #(
  parameter int CNT_W = 3
);
  logic             req0;
  logic             req1;
  logic             dir0;
  logic             dir1;
  logic [CNT_W-1:0] steps0;
  logic [CNT_W-1:0] steps1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             busy;
  logic             mode;
  logic [CNT_W-1:0] count;

  modport master (
    output req0, req1, dir0, dir1, steps0, steps1,
    input  gnt0, gnt1, done0, done1, busy, mode, count
  );

  modport slave (
    input  req0, req1, dir0, dir1, steps0, steps1,
    output gnt0, gnt1, done0, done1, busy, mode, count
  );
endinterface

// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - round-robin arbiter sharing one wrap-around up/down counter
module counter_arbiter #(
  parameter int CNT_W = 3
) (
  input logic              clk,
  input logic              reset,
  counter_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic             grant;
  logic             grant_id;
  logic             owner;
  logic             ptr;
  logic             mode;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_id  = ptr;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant     = 1'b1;
          grant_id  = (bus.req0 && bus.req1) ? ptr : bus.req1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // remaining of 1 hits zero this edge; 0 means a zero-step request
        if (remaining <= ONE) begin
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= 1'b0;
      ptr       <= 1'b0;
      mode      <= 1'b0;
      remaining <= '0;
      count     <= '0;
    end else begin
      if (grant) begin
        owner     <= grant_id;
        ptr       <= ~grant_id;
        mode      <= grant_id ? bus.dir1 : bus.dir0;
        remaining <= grant_id ? bus.steps1 : bus.steps0;
      end
      if (state == RUN && remaining != '0) begin
        count     <= mode ? count + ONE : count - ONE;
        remaining <= remaining - ONE;
      end
    end
  end

  assign bus.gnt0  = (state != IDLE) && !owner;
  assign bus.gnt1  = (state != IDLE) && owner;
  assign bus.done0 = (state == DONE) && !owner;
  assign bus.done1 = (state == DONE) && owner;
  assign bus.busy  = (state != IDLE);
  assign bus.mode  = mode;
  assign bus.count = count;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - directed self-checking bench for counter_arbiter
module tb_counter_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   exp_count;

  counter_arbiter_if #(.CNT_W(3)) bus ();

  counter_arbiter #(.CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int wrap(input int v);
    return v & 7;
  endfunction

  // Issue one request in the current IDLE cycle and check every cycle until IDLE again.
  task automatic run_op(input int id, input int d, input int n, input bit scramble);
    int last;
    int moved;
    last = (n == 0) ? 2 : n + 1;
    if (id == 0) begin
      bus.req0 = 1'b1; bus.dir0 = d[0]; bus.steps0 = n[2:0];
    end else begin
      bus.req1 = 1'b1; bus.dir1 = d[0]; bus.steps1 = n[2:0];
    end
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        if (scramble) begin
          bus.dir0 = ~d[0]; bus.steps0 = 3'd1;
          bus.dir1 = ~d[0]; bus.steps1 = 3'd1;
        end
      end
      moved = (k - 1 < n) ? k - 1 : n;
      check($sformatf("gnt%0d_k%0d", id, k), (id == 0) ? bus.gnt0 : bus.gnt1, (k <= last) ? 1 : 0);
      check($sformatf("gnt_other_k%0d", k), (id == 0) ? bus.gnt1 : bus.gnt0, 0);
      check($sformatf("done%0d_k%0d", id, k), (id == 0) ? bus.done0 : bus.done1, (k == last) ? 1 : 0);
      check($sformatf("done_other_k%0d", k), (id == 0) ? bus.done1 : bus.done0, 0);
      check($sformatf("busy_k%0d", k), bus.busy, (k <= last) ? 1 : 0);
      check($sformatf("count_k%0d", k), bus.count, wrap(exp_count + (d ? moved : -moved)));
    end
    check("mode_after_op", bus.mode, d);
    exp_count = wrap(exp_count + (d ? n : -n));
  endtask

  initial begin
    int  owner;
    int  ph;
    bit  saw_done;
    n_checks  = 0;
    n_fail    = 0;
    exp_count = 0;
    reset     = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.dir0 = 1'b0; bus.dir1 = 1'b0;
    bus.steps0 = '0; bus.steps1 = '0;
    repeat (2) @(negedge clk);
    check("rst_count", bus.count, 0);
    check("rst_mode", bus.mode, 0);
    check("rst_gnt", {bus.gnt0, bus.gnt1}, 0);
    check("rst_done", {bus.done0, bus.done1}, 0);
    check("rst_busy", bus.busy, 0);
    reset = 1'b0;
    @(negedge clk);

    run_op(0, 1, 3, 1'b0);          // 1,2,3
    run_op(1, 0, 2, 1'b0);          // 3 -> 1
    run_op(1, 0, 3, 1'b0);          // 0,7,6 through the wrap

    // Both requesting continuously: pointer favours 0 after the two req1 grants.
    bus.req0 = 1'b1; bus.dir0 = 1'b1; bus.steps0 = 3'd1;
    bus.req1 = 1'b1; bus.dir1 = 1'b0; bus.steps1 = 3'd1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      owner = (c / 3) % 2;
      ph    = c % 3;
      check($sformatf("rr_gnt0_c%0d", c), bus.gnt0, (owner == 0 && ph < 2) ? 1 : 0);
      check($sformatf("rr_gnt1_c%0d", c), bus.gnt1, (owner == 1 && ph < 2) ? 1 : 0);
      check($sformatf("rr_done0_c%0d", c), bus.done0, (owner == 0 && ph == 1) ? 1 : 0);
      check($sformatf("rr_done1_c%0d", c), bus.done1, (owner == 1 && ph == 1) ? 1 : 0);
      check($sformatf("rr_count_c%0d", c), bus.count,
            (ph == 0) ? ((owner == 0) ? 6 : 7) : ((owner == 0) ? 7 : 6));
      if (c == 11) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
    end
    exp_count = 6;
    @(negedge clk);
    check("rr_idle_busy", bus.busy, 0);

    run_op(0, 1, 0, 1'b0);          // zero steps leaves count at 6

    // Reset during the second RUN cycle of a five-step up operation.
    bus.req0 = 1'b1; bus.dir0 = 1'b1; bus.steps0 = 3'd5;
    @(negedge clk);
    bus.req0 = 1'b0;
    check("ab_gnt0_run1", bus.gnt0, 1);
    @(negedge clk);
    check("ab_count_run2", bus.count, 7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("ab_count", bus.count, 0);
    check("ab_gnt", {bus.gnt0, bus.gnt1}, 0);
    check("ab_done", {bus.done0, bus.done1}, 0);
    check("ab_busy", bus.busy, 0);
    check("ab_mode", bus.mode, 0);
    saw_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1 || bus.busy) saw_done = 1'b1;
    end
    check("ab_no_done_later", saw_done, 0);
    exp_count = 0;

    run_op(0, 1, 4, 1'b1);          // inputs scrambled after grant: still 1,2,3,4

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Shares one 3-bit wrap-around up/down counter between two requesters. Each requester asks for a direction and a step count, waits for its grant, and gets a one-cycle done pulse when its steps are applied. The block owns the counter state and exposes the current count and applied direction. It is the sequencing front-end for counter datapaths in the sequential-circuits lab designs.

## Interface
- CNT_W, 3, counter and step-count width; count wraps modulo 2^CNT_W
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req0, req1  input  1  request from requester 0 / 1; level-sensitive
- dir0, dir1  input  1  requested direction; 1 = up, 0 = down; sampled only at grant
- steps0, steps1  input  CNT_W  number of steps requested; sampled only at grant
- gnt0, gnt1  output  1  requester owns the counter; at most one high at a time
- done0, done1  output  1  one-cycle pulse; the owner's operation is complete
- busy  output  1  high in RUN and DONE
- mode  output  1  direction of the current or last operation
- count  output  CNT_W  current counter value

## Operation
- Reset values: state IDLE; count=0; mode=0; gnt0=gnt1=0; done0=done1=0; busy=0; round-robin pointer favours requester 0.
- Reset has priority over every other event, including mid-RUN. An operation aborted by reset produces no done pulse.
- State IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester favoured by the pointer. The pointer then favours the other requester.
  - A single-requester grant also moves the pointer to favour the other requester.
  - On a grant edge: latch dir into mode, latch steps into a remaining register, set the owner, and go to RUN.
- State RUN, each edge:
  - If remaining != 0: count <= count+1 when mode=1, count-1 when mode=0, both modulo 2^CNT_W. Then remaining <= remaining-1.
  - If remaining becomes 0 this edge, or was already 0, go to DONE.
  - steps=0 therefore gives one RUN cycle with no count change.
- State DONE: done pulse for the owner; gnt held; count held. Next edge goes to IDLE, which clears the owner.
- Wrap-around: up from 7 gives 0; down from 0 gives 7 (CNT_W=3). No saturation, no flag.
- Dropping req during RUN or DONE is ignored; the operation always completes.
- dir and steps changes after the grant edge are ignored.
- A req still high in IDLE after its done is a new request; round-robin still applies.
- count and mode hold their values in IDLE and DONE.

## Timing
- Request first seen high in IDLE in cycle T means gnt is high from T+1.
- steps=N, N>=1:
  - RUN covers cycles T+1..T+N.
  - count takes new values in cycles T+2..T+N+1.
  - DONE and the done pulse are in cycle T+N+1.
  - gnt goes low and the state is IDLE in T+N+2.
- steps=0: RUN in T+1, DONE/done in T+2, IDLE in T+3.
- Back-to-back: the earliest next grant decision is in IDLE cycle T+N+2, so the next gnt is high in T+N+3. There is one idle cycle between owners.
- gnt0&gnt1 and done0&done1 are never high together. done_x high implies gnt_x high.

## Test plan
- Reset, then req0=1, dir0=1, steps0=3 in cycle T -> gnt0 high T+1; count 1,2,3 in T+2..T+4; done0 pulse in T+4; gnt0 low T+5; count holds 3.
- From count=1, req1 with dir1=0, steps1=3 -> count 0,7,6; done1 single pulse; mode=0.
- req0 and req1 both high continuously, steps=1 each -> grants alternate 0,1,0,1 with one IDLE cycle between owners; never both granted.
- steps0=0 -> gnt0 for T+1..T+2, done0 in T+2, count unchanged.
- Reset asserted in the 2nd RUN cycle of a steps=5 up operation -> next cycle count=0, IDLE, gnt/done/busy low, no done pulse ever issued.
- req0 dropped and dir0/steps0 changed after grant (steps0=4) -> four counts in the original direction still applied, done0 still pulses.
